ir_frame_receiver: RTL and testbench
====================================

// Module: ir_frame_receiver
// PURPOSE
//  Parametrised successor to the IR bit shift register. Assembles N serial IR bits into a frame in the
//  single clk domain: bits arrive as bit_strobe enables, not as a shift clock. Provides a
//  valid/ack-handshaked output register, selectable bit order, an inter-bit timeout and overrun detection.
//  Sits between the IR edge/bit decoder and the command decoder.
// PARAMETERS
//  N          33      frame length in bits (2..64)
//  MSB_FIRST  1       1: first received bit ends in data[N-1]; 0: first received bit ends in data[0]
//  TIMEOUT    50000   max clk cycles between bit_strobes inside a frame before abort (>=2)
//  CW         $clog2(N+1)   bit_count width (localparam, not overridable)
// PORTS
//  clk          in   1    system clock, all logic on rising edge
//  reset        in   1    synchronous, active-high reset
//  en           in   1    block enable; low forces IDLE and discards any partial frame
//  start        in   1    frame start (leader detected), 1-cycle pulse
//  bit_strobe   in   1    1-cycle pulse: serial_in holds a valid bit this cycle
//  serial_in    in   1    decoded bit value
//  data_ack     in   1    consumer accepts data; clears data_valid
//  clr_err      in   1    clears sticky overrun
//  data         out  N    last completed frame, held until replaced
//  data_valid   out  1    data holds an unacknowledged frame
//  busy         out  1    high in RECV state
//  bit_count    out  CW   bits received in current frame (0..N-1)
//  overrun      out  1    sticky: a completed frame was dropped because data_valid was still high
//  timeout_err  out  1    1-cycle pulse on inter-bit timeout abort
// BEHAVIOUR
//  Reset: state=IDLE; shift reg, data, bit_count, idle counter = 0; data_valid, busy, overrun, timeout_err = 0.
//  FSM states: IDLE, RECV. Priority each cycle: reset > !en > start > timeout > bit_strobe.
//  IDLE: start & en -> RECV; shift reg, bit_count and idle counter cleared. bit_strobe in IDLE is ignored.
//  RECV, bit_strobe:
//   - MSB_FIRST=1: sr <= {sr[N-2:0],serial_in}.
//   - MSB_FIRST=0: sr <= {serial_in,sr[N-1:1]}.
//   - bit_count++ and idle counter cleared.
//  RECV, bit_strobe with bit_count==N-1 (Nth bit), frame complete -> IDLE, bit_count=0:
//   - If data_valid==0 or data_ack this cycle: data <= assembled frame incl. this bit; data_valid=1 next cycle.
//   - Else: frame dropped, data unchanged, overrun<=1.
//   - Latency: data/data_valid update 1 cycle after the Nth strobe edge.
//  RECV, no strobe: idle counter++. When it reaches TIMEOUT-1:
//   - timeout_err=1 for exactly one cycle; -> IDLE; partial frame discarded; data/data_valid untouched.
//  RECV, start (with or without strobe): restart.
//   - sr, bit_count, idle counter cleared; the strobe bit in that cycle is discarded.
//  !en: -> IDLE, partial frame discarded; data, data_valid and overrun keep their values; handshake still works.
//  data_ack with data_valid=1 and no completion: data_valid<=0. data_ack with data_valid=0: no effect.
//  overrun clears only on reset or clr_err. clr_err coincident with a new drop: overrun stays 1.
//  busy = (state==RECV). bit_count is a registered output and never exceeds N-1.
//  Idle counter width = $clog2(TIMEOUT); it saturates and never wraps.
// TESTING
//  1. N=33, MSB_FIRST=1, start then 33 strobes with bits 1,0,1,0...:
//     -> data=33'h155555555, data_valid=1 one cycle after strobe 33, busy low.
//  2. MSB_FIRST=0, N=8, bits 1,0,0,0,0,0,0,0 -> data=8'h01; MSB_FIRST=1 same bits -> data=8'h80.
//  3. Two full frames with no data_ack between them:
//     -> second frame dropped, overrun=1, data = first frame.
//     -> clr_err -> overrun=0.
//     -> Repeat with data_ack in the completing cycle -> second frame stored, no overrun.
//  4. TIMEOUT=16, start, 5 strobes, then silence:
//     -> timeout_err pulses 1 cycle exactly 15 cycles after the 5th strobe, busy=0, data_valid unchanged.
//  5. start mid-frame at bit_count=10 -> bit_count=0 next cycle; a following full N-bit frame is assembled correctly.
//  6. Mid-frame reset and mid-frame en=0:
//     -> reset: all outputs zero next cycle.
//     -> en=0: busy=0 and later strobes are ignored until the next start.

Source files
------------

// File: rtl/ir_frame_receiver.sv
// Collects N bit_strobe-qualified IR bits into a frame and presents it through a valid/ack output register.
// Also aborts a frame when bits stop arriving and flags frames lost because the consumer was still busy.
module ir_frame_receiver #(
    parameter int N         = 33,
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    start,
    input  logic                    bit_strobe,
    input  logic                    serial_in,
    input  logic                    data_ack,
    input  logic                    clr_err,
    output logic [N-1:0]            data,
    output logic                    data_valid,
    output logic                    busy,
    output logic [$clog2(N+1)-1:0]  bit_count,
    output logic                    overrun,
    output logic                    timeout_err
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(TIMEOUT);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t         state, state_next;
    logic [N-1:0]   sr, sr_shifted;
    logic [IW-1:0]  idle_cnt;
    logic           recv_active;
    logic           timeout_hit;
    logic           frame_done;
    logic           store;
    logic           drop;

    always_comb begin
        if (MSB_FIRST) begin
            sr_shifted = {sr[N-2:0], serial_in};
        end else begin
            sr_shifted = {serial_in, sr[N-1:1]};
        end
    end

    // Events below start in the priority chain only count while enabled, receiving and not restarted.
    assign recv_active = (state == RECV) && en && !start;
    assign timeout_hit = recv_active && !bit_strobe && (idle_cnt == IW'(TIMEOUT - 2));
    assign frame_done  = recv_active && bit_strobe && (bit_count == CW'(N - 1));
    assign store       = frame_done && (!data_valid || data_ack);
    assign drop        = frame_done && data_valid && !data_ack;
    assign busy        = (state == RECV);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en && start) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (start) begin
                    state_next = RECV;
                end else if (timeout_hit || frame_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sr          <= '0;
            bit_count   <= '0;
            idle_cnt    <= '0;
            data        <= '0;
            data_valid  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            timeout_err <= timeout_hit;

            if (!en) begin
                bit_count <= '0;
            end else if (start) begin
                sr        <= '0;
                bit_count <= '0;
                idle_cnt  <= '0;
            end else if (state == RECV) begin
                if (bit_strobe) begin
                    sr        <= sr_shifted;
                    idle_cnt  <= '0;
                    bit_count <= frame_done ? '0 : bit_count + CW'(1);
                end else begin
                    if (idle_cnt < IW'(TIMEOUT - 1)) begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                    if (timeout_hit) begin
                        bit_count <= '0;
                    end
                end
            end

            // The output register keeps serving the handshake even while the receiver is disabled.
            if (store) begin
                data       <= sr_shifted;
                data_valid <= 1'b1;
            end else if (data_ack) begin
                data_valid <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ir_frame_receiver.sv
// Drives three receiver variants (33-bit MSB-first, 8-bit LSB-first, 8-bit MSB-first) from shared inputs
// and compares every output each cycle against a frame-level reference model.
module tb_ir_frame_receiver;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        bit_strobe = 1'b0;
    logic        serial_in = 1'b0;
    logic        data_ack = 1'b0;
    logic        clr_err = 1'b0;

    logic [32:0] data_a;
    logic [7:0]  data_b, data_c;
    logic        dv_a, dv_b, dv_c;
    logic        busy_a, busy_b, busy_c;
    logic [5:0]  bc_a;
    logic [3:0]  bc_b, bc_c;
    logic        ov_a, ov_b, ov_c;
    logic        to_a, to_b, to_c;

    int checks = 0;
    int errors = 0;

    ir_frame_receiver #(.N(33), .MSB_FIRST(1'b1), .TIMEOUT(TO)) dut_a (
        .clk(clk), .reset(reset), .en(en), .start(start), .bit_strobe(bit_strobe),
        .serial_in(serial_in), .data_ack(data_ack), .clr_err(clr_err),
        .data(data_a), .data_valid(dv_a), .busy(busy_a), .bit_count(bc_a),
        .overrun(ov_a), .timeout_err(to_a)
    );

    ir_frame_receiver #(.N(8), .MSB_FIRST(1'b0), .TIMEOUT(TO)) dut_b (
        .clk(clk), .reset(reset), .en(en), .start(start), .bit_strobe(bit_strobe),
        .serial_in(serial_in), .data_ack(data_ack), .clr_err(clr_err),
        .data(data_b), .data_valid(dv_b), .busy(busy_b), .bit_count(bc_b),
        .overrun(ov_b), .timeout_err(to_b)
    );

    ir_frame_receiver #(.N(8), .MSB_FIRST(1'b1), .TIMEOUT(TO)) dut_c (
        .clk(clk), .reset(reset), .en(en), .start(start), .bit_strobe(bit_strobe),
        .serial_in(serial_in), .data_ack(data_ack), .clr_err(clr_err),
        .data(data_c), .data_valid(dv_c), .busy(busy_c), .bit_count(bc_c),
        .overrun(ov_c), .timeout_err(to_c)
    );

    always #5 clk = ~clk;

    // Reference model: bits are recorded by arrival index and placed into the frame only on completion.
    int          n_of[3]   = '{33, 8, 8};
    bit          msb_of[3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] m_data[3];
    bit          m_valid[3], m_ov[3], m_busy[3], m_tout[3];
    int          m_cnt[3], m_last[3];
    bit          m_arr[3][64];
    int          cyc = 0;

    function automatic logic [63:0] assemble(int k);
        logic [63:0] f;
        f = '0;
        for (int j = 0; j < n_of[k]; j++) begin
            f[msb_of[k] ? (n_of[k] - 1 - j) : j] = m_arr[k][j];
        end
        return f;
    endfunction

    task automatic model_step();
        bit done, was_valid;
        logic [63:0] frame;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            m_tout[k] = 1'b0;
            if (reset) begin
                m_data[k] = '0; m_valid[k] = 1'b0; m_ov[k] = 1'b0;
                m_busy[k] = 1'b0; m_cnt[k] = 0;
                continue;
            end
            done = 1'b0;
            frame = '0;
            if (!en) begin
                m_busy[k] = 1'b0; m_cnt[k] = 0;
            end else if (start) begin
                m_busy[k] = 1'b1; m_cnt[k] = 0; m_last[k] = cyc;
            end else if (m_busy[k]) begin
                if (!bit_strobe && (cyc - m_last[k] == TO - 1)) begin
                    m_tout[k] = 1'b1; m_busy[k] = 1'b0; m_cnt[k] = 0;
                end else if (bit_strobe) begin
                    m_arr[k][m_cnt[k]] = serial_in;
                    m_cnt[k]++;
                    m_last[k] = cyc;
                    if (m_cnt[k] == n_of[k]) begin
                        frame = assemble(k);
                        done = 1'b1; m_busy[k] = 1'b0; m_cnt[k] = 0;
                    end
                end
            end
            was_valid = m_valid[k];
            if (done && (!was_valid || data_ack)) begin
                m_data[k] = frame; m_valid[k] = 1'b1;
            end else if (data_ack) begin
                m_valid[k] = 1'b0;
            end
            if (done && was_valid && !data_ack) m_ov[k] = 1'b1;
            else if (clr_err) m_ov[k] = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic check_all();
        logic [63:0] d, c;
        logic v, b, o, t;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin d = 64'(data_a); v = dv_a; b = busy_a; c = 64'(bc_a); o = ov_a; t = to_a; end
                1: begin d = 64'(data_b); v = dv_b; b = busy_b; c = 64'(bc_b); o = ov_b; t = to_b; end
                default: begin d = 64'(data_c); v = dv_c; b = busy_c; c = 64'(bc_c); o = ov_c; t = to_c; end
            endcase
            checkOutput($sformatf("data[%0d]", k), d, m_data[k]);
            checkOutput($sformatf("data_valid[%0d]", k), 64'(v), 64'(m_valid[k]));
            checkOutput($sformatf("busy[%0d]", k), 64'(b), 64'(m_busy[k]));
            checkOutput($sformatf("bit_count[%0d]", k), c, 64'(m_cnt[k]));
            checkOutput($sformatf("overrun[%0d]", k), 64'(o), 64'(m_ov[k]));
            checkOutput($sformatf("timeout_err[%0d]", k), 64'(t), 64'(m_tout[k]));
        end
    endtask

    // One clock: pulses are held across the edge, then outputs are sampled 1 time unit later.
    task automatic applyStimulus(input bit st, input bit strb, input bit sin, input bit ack, input bit clr);
        start = st; bit_strobe = strb; serial_in = sin; data_ack = ack; clr_err = clr;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        start = 1'b0; bit_strobe = 1'b0; serial_in = 1'b0; data_ack = 1'b0; clr_err = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    // Sends one 33-bit frame of random bits with short random gaps; returns it as received MSB-first.
    task automatic send_random_frame(input bit ack_last, output logic [32:0] frame);
        bit b;
        frame = '0;
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 33; i++) begin
            idle_cycles($urandom_range(0, 3));
            b = 1'($urandom_range(0, 1));
            frame = {frame[31:0], b};
            applyStimulus(0, 1, b, ack_last && (i == 32), 0);
        end
    endtask

    initial begin
        logic [32:0] f1, f2, f3;
        int pulse_at;

        // Reset state
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("reset_data", 64'(data_a), 64'h0);
        checkOutput("reset_busy", 64'(busy_a), 64'h0);
        reset = 1'b0;
        en = 1'b1;
        idle_cycles(2);

        // Alternating 1,0,1,0... frame
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 33; i++) begin
            applyStimulus(0, 1, (i % 2 == 0), 0, 0);
            if (i == 32) begin
                checkOutput("alt_data33", 64'(data_a), 64'h1_5555_5555);
                checkOutput("alt_valid33", 64'(dv_a), 64'h1);
                checkOutput("alt_busy33", 64'(busy_a), 64'h0);
            end
        end
        checkOutput("alt_data8_lsb", 64'(data_b), 64'h55);
        checkOutput("alt_data8_msb", 64'(data_c), 64'hAA);
        applyStimulus(0, 0, 0, 1, 0);

        // Bit order: 1 followed by seven zeros
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, (i == 0), 0, 0);
        checkOutput("order_lsb_first", 64'(data_b), 64'h01);
        checkOutput("order_msb_first", 64'(data_c), 64'h80);
        checkOutput("order_valid", 64'(dv_b), 64'h1);
        applyStimulus(0, 0, 0, 1, 0);

        // Overrun: second frame without ack is dropped, then cleared, then ack-in-completion stores
        send_random_frame(0, f1);
        send_random_frame(0, f2);
        checkOutput("overrun_set", 64'(ov_a), 64'h1);
        checkOutput("overrun_keeps_first", 64'(data_a), 64'(f1));
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("overrun_cleared", 64'(ov_a), 64'h0);
        send_random_frame(1, f3);
        checkOutput("ack_in_completion_data", 64'(data_a), 64'(f3));
        checkOutput("ack_in_completion_valid", 64'(dv_a), 64'h1);
        checkOutput("ack_in_completion_no_overrun", 64'(ov_a), 64'h0);

        // Inter-bit timeout after five strobes
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, 0);
        pulse_at = -1;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            if (to_a === 1'b1 && pulse_at < 0) pulse_at = i;
        end
        checkOutput("timeout_delay", 64'(pulse_at), 64'd15);
        checkOutput("timeout_valid_kept", 64'(dv_a), 64'h1);

        // Restart mid-frame at bit_count 10, strobe in the restart cycle is discarded
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, 0, 0);
        checkOutput("restart_count_before", 64'(bc_a), 64'd10);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("restart_count_after", 64'(bc_a), 64'd0);
        f1 = '0;
        for (int i = 0; i < 33; i++) begin
            f1 = {f1[31:0], 1'($urandom_range(0, 1))};
            applyStimulus(0, 1, f1[0], 0, 0);
        end
        checkOutput("restart_frame", 64'(data_a), 64'(f1));

        // Mid-frame reset, then mid-frame disable
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 1, 0, 0);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("midreset_data", 64'(data_a), 64'h0);
        checkOutput("midreset_valid", 64'(dv_a), 64'h0);
        checkOutput("midreset_count", 64'(bc_a), 64'h0);
        reset = 1'b0;
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0, 0);
        en = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("disable_busy", 64'(busy_a), 64'h0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0);
        en = 1'b1;
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 1, 0, 0);
        checkOutput("disable_ignores_strobes", 64'(bc_a), 64'h0);
        send_random_frame(0, f2);
        checkOutput("after_disable_frame", 64'(data_a), 64'(f2));

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            applyStimulus($urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                          $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
